counter_monitor: RTL

Passive checker on the receiving end of the free-running counter's output bus. It samples the counter value every enabled clock, acquires lock on an incrementing sequence, then flags any sample that is not previous+1 (mod 2^WIDTH). It keeps saturating error and wrap statistics. It sits in simulation benches and in on-chip self-test next to the counter instance, driven from the same clock.

---
 rtl/counter_monitor.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/counter_monitor.sv
// Passive sequence checker for a free-running counter bus: locks onto an
// incrementing sequence, then flags and counts every sample that breaks it.
`timescale 1ns/1ps

// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no sample seen since reset; next valid sample seeds expected
// S_ACQUIRE | counting consecutive correct increments toward lock
// S_LOCKED  | every valid sample is checked; a miss drops back to acquire
module counter_monitor #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [WIDTH-1:0]  value_i,
    input  logic              valid_i,
    input  logic              clear_i,
    output logic              locked_o,
    output logic              mismatch_o,
    output logic              error_o,
    output logic [ERR_W-1:0]  err_count_o,
    output logic [WRAP_W-1:0] wrap_count_o,
    output logic [WIDTH-1:0]  expected_o
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_expected;
    logic [WIDTH-1:0]  w_expected_nxt;
    logic [GOOD_W-1:0] r_good;
    logic [GOOD_W-1:0] w_good_nxt;
    logic              r_mismatch;
    logic              r_error;
    logic [ERR_W-1:0]  r_err_count;
    logic [WRAP_W-1:0] r_wrap_count;

    logic [WIDTH-1:0]  w_value_inc;
    logic [GOOD_W-1:0] w_good_inc;
    logic              w_match;
    logic              w_mismatch;
    logic              w_wrap;
    logic              w_error_nxt;
    logic [ERR_W-1:0]  w_err_base;
    logic [ERR_W-1:0]  w_err_nxt;
    logic [WRAP_W-1:0] w_wrap_base;
    logic [WRAP_W-1:0] w_wrap_nxt;

    // Truncation to WIDTH makes all-ones -> 0 a legal increment.
    assign w_value_inc = value_i + 1'b1;
    assign w_good_inc  = r_good + 1'b1;
    assign w_match     = (value_i == r_expected);

    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_good_nxt     = r_good;
        w_mismatch     = 1'b0;
        w_wrap         = 1'b0;
        if (valid_i) begin
            w_expected_nxt = w_value_inc;
            case (r_state)
                S_IDLE: begin
                    w_good_nxt  = '0;
                    w_state_nxt = S_ACQUIRE;
                end
                S_ACQUIRE: begin
                    if (w_match) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == GOOD_LOCK) begin
                            w_state_nxt = S_LOCKED;
                        end
                    end else begin
                        w_good_nxt = '0;
                    end
                end
                S_LOCKED: begin
                    if (w_match) begin
                        w_wrap = (value_i == '0);
                    end else begin
                        w_mismatch  = 1'b1;
                        w_good_nxt  = '0;
                        w_state_nxt = S_ACQUIRE;
                    end
                end
                default: begin
                    w_good_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // A clear zeroes the base first so a coincident event still counts as one.
    always_comb begin
        w_err_base  = clear_i ? '0 : r_err_count;
        w_wrap_base = clear_i ? '0 : r_wrap_count;
        w_err_nxt   = w_err_base;
        w_wrap_nxt  = w_wrap_base;
        w_error_nxt = clear_i ? 1'b0 : r_error;
        if (w_mismatch) begin
            w_error_nxt = 1'b1;
            if (w_err_base != '1) begin
                w_err_nxt = w_err_base + 1'b1;
            end
        end
        if (w_wrap && (w_wrap_base != '1)) begin
            w_wrap_nxt = w_wrap_base + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state      <= S_IDLE;
            r_expected   <= '0;
            r_good       <= '0;
            r_mismatch   <= 1'b0;
            r_error      <= 1'b0;
            r_err_count  <= '0;
            r_wrap_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_expected   <= w_expected_nxt;
            r_good       <= w_good_nxt;
            r_mismatch   <= w_mismatch;
            r_error      <= w_error_nxt;
            r_err_count  <= w_err_nxt;
            r_wrap_count <= w_wrap_nxt;
        end
    end

    assign locked_o     = (r_state == S_LOCKED);
    assign mismatch_o   = r_mismatch;
    assign error_o      = r_error;
    assign err_count_o  = r_err_count;
    assign wrap_count_o = r_wrap_count;
    assign expected_o   = r_expected;

endmodule
